// File: rtl/score_sprite_reader_pkg.sv
// ----------------------------------------------------------------------------
// score_sprite_reader_pkg
//   Shared constants, types and helpers for the score sprite reader.
//   - Sprite geometry (SPR_W x SPR_H) and ROM depth.
//   - Score ceiling shown on screen (MAX_SCORE).
//   - Converter FSM state encoding.
//   - bcd3_t: three packed BCD nibbles, index 2 = hundreds, 0 = ones.
//   - dabble_step(): one double-dabble iteration (adjust, then shift).
//   - clamp_score(): saturate a binary score at MAX_SCORE.
// ----------------------------------------------------------------------------
package score_sprite_reader_pkg;

   localparam int SPR_W     = 20;
   localparam int SPR_H     = 20;
   localparam int SPR_DEPTH = SPR_W * SPR_H;
   localparam int MAX_SCORE = 999;
   localparam int DIGITS    = 3;
   localparam int BIN_W     = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } conv_state_t;

   typedef logic [DIGITS-1:0][3:0] bcd3_t;

   // Every nibble >= 5 gets +3 so the following left shift carries a
   // decimal ten into the next nibble; the new binary bit enters at bit 0.
   function automatic bcd3_t dabble_step(input bcd3_t acc, input logic in_bit);
      bcd3_t       adj;
      logic [12:0] shifted;
      for (int i = 0; i < DIGITS; i++) begin
         adj[i] = (acc[i] >= 4'd5) ? acc[i] + 4'd3 : acc[i];
      end
      shifted = {adj, in_bit};
      return shifted[11:0];
   endfunction

   function automatic logic [BIN_W-1:0] clamp_score(input logic [BIN_W-1:0] s);
      return (s > BIN_W'(MAX_SCORE)) ? BIN_W'(MAX_SCORE) : s;
   endfunction

endpackage

// File: rtl/score_sprite_reader_if.sv
// ----------------------------------------------------------------------------
// score_sprite_reader_if
//   Read bus between the score reader and the ten digit sprite ROMs.
//   o_numberaddr  10  sprite address, row*SPR_W + col
//   o_digit_sel    4  BCD digit selecting which ROM the parent muxes in
//   i_numberdata   8  muxed ROM data, one cycle after the address
//   master = score reader, slave = ROM side.
// ----------------------------------------------------------------------------
interface score_sprite_reader_if;

   logic [9:0] o_numberaddr;
   logic [3:0] o_digit_sel;
   logic [7:0] i_numberdata;

   modport master (
      output o_numberaddr,
      output o_digit_sel,
      input  i_numberdata
   );

   modport slave (
      input  o_numberaddr,
      input  o_digit_sel,
      output i_numberdata
   );

endinterface

// File: rtl/score_sprite_reader_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// score_sprite_reader_bin2bcd_seq
//   Sequential double-dabble converter, one binary bit per cycle.
//   i_clk2  in   pixel clock
//   i_rst   in   synchronous active-high reset
//   start   in   begin (or restart) a conversion of bin
//   bin     in   10-bit binary score, clamped to MAX_SCORE on start
//   busy    out  converter is in CONV or LOAD
//   done    out  high for the LOAD cycle; bcd is valid while done
//   bcd     out  accumulator, three BCD nibbles
// ----------------------------------------------------------------------------
module score_sprite_reader_bin2bcd_seq
   import score_sprite_reader_pkg::*;
(
   input  logic             i_clk2,
   input  logic             i_rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output bcd3_t            bcd
);

   conv_state_t      state;
   logic [BIN_W-1:0] shift;
   bcd3_t            acc;
   logic [3:0]       bit_cnt;

   // NOTE: every register here is assigned with <= so all of them update from
   // the same pre-edge values; a blocking = would let acc see this cycle's
   // shift instead of last cycle's.
   always_ff @(posedge i_clk2) begin
      if (i_rst) begin
         state   <= IDLE;
         shift   <= '0;
         acc     <= '0;
         bit_cnt <= '0;
      end else if (start) begin
         // A new pulse always wins, even mid-conversion.
         state   <= CONV;
         shift   <= clamp_score(bin);
         acc     <= '0;
         bit_cnt <= '0;
      end else begin
         case (state)
            IDLE: state <= IDLE;
            CONV: begin
               acc     <= dabble_step(acc, shift[BIN_W-1]);
               shift   <= {shift[BIN_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'(BIN_W - 1)) begin
                  state <= LOAD;
               end
            end
            LOAD:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == LOAD);
   assign bcd  = acc;

endmodule

// File: rtl/score_sprite_reader.sv
// ----------------------------------------------------------------------------
// score_sprite_reader
//   Draws the 3-digit score from the digit sprite ROMs. The score is converted
//   to BCD once per frame during vblank; each pixel is mapped to a cell, a
//   ROM address and a digit select, and the ROM's registered read is absorbed
//   by a fixed 3-cycle alignment pipeline.
//   i_clk2         in   pixel clock
//   i_rst          in   synchronous active-high reset
//   i_x, i_y       in   current pixel position
//   i_active       in   visible-area flag for (i_x, i_y)
//   i_frame_start  in   1-cycle pulse at start of vblank
//   i_score        in   binary score, sampled on i_frame_start
//   rom            bus  o_numberaddr / o_digit_sel out, i_numberdata in
//   o_pixel        out  sprite pixel, 0 when o_hit = 0
//   o_hit          out  opaque score pixel
//   o_active_d     out  i_active aligned with o_pixel / o_hit
// ----------------------------------------------------------------------------
module score_sprite_reader
   import score_sprite_reader_pkg::*;
#(
   parameter logic [9:0] X0          = 10'd560,
   parameter logic [9:0] Y0          = 10'd16,
   parameter int         GAP         = 4,
   parameter logic [7:0] TRANSPARENT = 8'h00,
   parameter bit         LEAD_BLANK  = 1'b1
) (
   input  logic                         i_clk2,
   input  logic                         i_rst,
   input  logic [9:0]                   i_x,
   input  logic [9:0]                   i_y,
   input  logic                         i_active,
   input  logic                         i_frame_start,
   input  logic [9:0]                   i_score,
   score_sprite_reader_if.master        rom,
   output logic [7:0]                   o_pixel,
   output logic                         o_hit,
   output logic                         o_active_d
);

   localparam int STRIDE = SPR_W + GAP;

   bcd3_t                   conv_bcd;
   logic                    conv_done;
   logic                    conv_busy_unused;
   bcd3_t                   digits;

   logic [DIGITS-1:0]       in_cell;
   logic [DIGITS-1:0][9:0]  cell_col;
   logic [DIGITS-1:0]       blank;
   logic                    lead_zero;
   logic                    in_rows;
   logic [9:0]              row;
   logic [9:0]              s1_col;
   logic [3:0]              s1_sel;
   logic                    s1_hit;
   logic [9:0]              addr_calc;

   logic                    hit_s1, act_s1, hit_s2, act_s2;
   logic                    opaque;

   score_sprite_reader_bin2bcd_seq u_bin2bcd (
      .i_clk2 (i_clk2),
      .i_rst  (i_rst),
      .start  (i_frame_start),
      .bin    (i_score),
      .busy   (conv_busy_unused),
      .done   (conv_done),
      .bcd    (conv_bcd)
   );

   // One comparator pair per cell; cell bounds are elaboration constants.
   for (genvar k = 0; k < DIGITS; k++) begin : g_cell
      localparam logic [9:0] BASE  = 10'(int'(X0) + k * STRIDE);
      localparam logic [9:0] LIMIT = 10'(int'(X0) + k * STRIDE + SPR_W);
      assign in_cell[k]  = (i_x >= BASE) && (i_x < LIMIT);
      assign cell_col[k] = i_x - BASE;
   end

   // Leading-zero blanking: cell k (k = 0 is hundreds) is blank when it and
   // every more significant digit are zero. The ones cell is never blanked.
   // NOTE: every variable gets a value before any conditional logic in this
   // block, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      blank     = '0;
      lead_zero = 1'b1;
      for (int k = 0; k < DIGITS - 1; k++) begin
         lead_zero = lead_zero && (digits[DIGITS-1-k] == 4'd0);
         blank[k]  = LEAD_BLANK && lead_zero;
      end
   end

   always_comb begin
      s1_hit = 1'b0;
      s1_col = '0;
      s1_sel = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (in_cell[k] && !blank[k]) begin
            s1_hit = 1'b1;
            s1_col = cell_col[k];
            s1_sel = digits[DIGITS-1-k];
         end
      end
      in_rows   = (i_y >= Y0) && (i_y < Y0 + 10'(SPR_H));
      s1_hit    = s1_hit && in_rows && i_active;
      row       = i_y - Y0;
      // row*20 as shift-and-add; holds only for SPR_W = 20.
      addr_calc = (row << 4) + (row << 2) + s1_col;
   end

   assign opaque = hit_s2 && (rom.i_numberdata != TRANSPARENT);

   always_ff @(posedge i_clk2) begin
      if (i_rst) begin
         digits           <= '0;
         rom.o_numberaddr <= '0;
         rom.o_digit_sel  <= '0;
         hit_s1           <= 1'b0;
         act_s1           <= 1'b0;
         hit_s2           <= 1'b0;
         act_s2           <= 1'b0;
         o_pixel          <= '0;
         o_hit            <= 1'b0;
         o_active_d       <= 1'b0;
      end else begin
         // Display digits only change when a conversion completes.
         if (conv_done) begin
            digits <= conv_bcd;
         end
         // Stage 1: address and select, zero outside a hit.
         rom.o_numberaddr <= s1_hit ? addr_calc : '0;
         rom.o_digit_sel  <= s1_hit ? s1_sel : '0;
         hit_s1           <= s1_hit;
         act_s1           <= i_active;
         // Stage 2: ROM is reading; carry the flags alongside it.
         hit_s2           <= hit_s1;
         act_s2           <= act_s1;
         // Stage 3: ROM data is valid, qualify it.
         o_hit            <= opaque;
         o_pixel          <= opaque ? rom.i_numberdata : '0;
         o_active_d       <= act_s2;
      end
   end

endmodule

// File: tb/tb_score_sprite_reader.sv
// ----------------------------------------------------------------------------
// tb_score_sprite_reader
//   Directed bench for score_sprite_reader with a registered ROM model whose
//   data is rom_fill XOR the low address byte.
// ----------------------------------------------------------------------------
module tb_score_sprite_reader;

   localparam int X0 = 560;
   localparam int Y0 = 16;

   logic       i_clk2 = 1'b0;
   logic       i_rst;
   logic [9:0] i_x;
   logic [9:0] i_y;
   logic       i_active;
   logic       i_frame_start;
   logic [9:0] i_score;
   logic [7:0] o_pixel;
   logic       o_hit;
   logic       o_active_d;
   logic [7:0] rom_fill;

   int checks = 0;
   int errors = 0;

   score_sprite_reader_if rom_bus ();

   score_sprite_reader dut (
      .i_clk2        (i_clk2),
      .i_rst         (i_rst),
      .i_x           (i_x),
      .i_y           (i_y),
      .i_active      (i_active),
      .i_frame_start (i_frame_start),
      .i_score       (i_score),
      .rom           (rom_bus.master),
      .o_pixel       (o_pixel),
      .o_hit         (o_hit),
      .o_active_d    (o_active_d)
   );

   always #5 i_clk2 = ~i_clk2;

   // Registered ROM: one cycle from address to data.
   always @(posedge i_clk2) begin
      rom_bus.i_numberdata <= rom_fill ^ rom_bus.o_numberaddr[7:0];
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One-cycle pixel at (x, y); checks stage-1 bus, that nothing appears at
   // N+2, and the qualified pixel at N+3.
   task automatic probe(input string tag, input int x, input int y, input bit act,
                        input bit in_field, input int exp_addr, input int exp_sel);
      logic [9:0] a;
      logic [7:0] data;
      bit         exp_hit;
      a       = in_field ? 10'(exp_addr) : 10'd0;
      data    = rom_fill ^ a[7:0];
      exp_hit = in_field && (data != 8'h00);
      @(negedge i_clk2);
      i_x = 10'(x); i_y = 10'(y); i_active = act;
      @(negedge i_clk2);
      check({tag, ".addr"}, 16'(rom_bus.o_numberaddr), 16'(a));
      check({tag, ".sel"},  16'(rom_bus.o_digit_sel), in_field ? 16'(exp_sel) : 16'd0);
      i_x = '0; i_y = '0; i_active = 1'b0;
      @(negedge i_clk2);
      check({tag, ".early"}, 16'(o_hit), 16'd0);
      @(negedge i_clk2);
      check({tag, ".hit"},   16'(o_hit), 16'(exp_hit));
      check({tag, ".pixel"}, 16'(o_pixel), exp_hit ? 16'(data) : 16'd0);
      check({tag, ".act"},   16'(o_active_d), 16'(act));
   endtask

   task automatic pulse_score(input int s);
      @(negedge i_clk2);
      i_score = 10'(s); i_frame_start = 1'b1;
      @(negedge i_clk2);
      i_frame_start = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge i_clk2);
   endtask

   // Hold a pixel in the ones cell (row 5, col 0 -> address 100).
   task automatic hold_ones_pixel();
      @(negedge i_clk2);
      i_x = 10'(X0 + 48); i_y = 10'(Y0 + 5); i_active = 1'b1;
   endtask

   initial begin
      rom_fill      = 8'hAB;
      i_rst         = 1'b1;
      i_frame_start = 1'b0;
      i_score       = '0;
      // Drive a hit pixel during reset: outputs must still be zero.
      i_x = 10'(X0 + 48); i_y = 10'(Y0); i_active = 1'b1;
      wait_cycles(4);
      check("rst.addr",  16'(rom_bus.o_numberaddr), 16'd0);
      check("rst.sel",   16'(rom_bus.o_digit_sel), 16'd0);
      check("rst.pixel", 16'(o_pixel), 16'd0);
      check("rst.hit",   16'(o_hit), 16'd0);
      check("rst.act",   16'(o_active_d), 16'd0);
      @(negedge i_clk2);
      i_rst = 1'b0; i_active = 1'b0;
      wait_cycles(4);

      // 1. score 123: digit change lands exactly 12 cycles after the pulse.
      hold_ones_pixel();
      pulse_score(123);
      wait_cycles(11);
      check("t1.before", 16'(rom_bus.o_digit_sel), 16'd0);
      @(negedge i_clk2);
      check("t1.after",  16'(rom_bus.o_digit_sel), 16'd3);
      check("t1.addr",   16'(rom_bus.o_numberaddr), 16'd100);
      i_active = 1'b0;
      wait_cycles(4);
      probe("t1.h", X0,      Y0, 1'b1, 1'b1, 0, 1);
      probe("t1.t", X0 + 24, Y0, 1'b1, 1'b1, 0, 2);
      probe("t1.o", X0 + 48, Y0, 1'b1, 1'b1, 0, 3);

      // 2. geometry corners, gap, outside rows/cells, inactive.
      probe("t2.corner", X0 + 19, Y0 + 19, 1'b1, 1'b1, 399, 1);
      probe("t2.gap",    X0 + 20, Y0,      1'b1, 1'b0, 0, 0);
      probe("t2.cell1",  X0 + 24, Y0,      1'b1, 1'b1, 0, 2);
      probe("t2.mid",    X0 + 30, Y0 + 7,  1'b1, 1'b1, 146, 2);
      probe("t2.past",   X0 + 68, Y0,      1'b1, 1'b0, 0, 0);
      probe("t2.below",  X0,      Y0 + 20, 1'b1, 1'b0, 0, 0);
      probe("t2.above",  X0,      Y0 - 1,  1'b1, 1'b0, 0, 0);
      probe("t2.inact",  X0,      Y0,      1'b0, 1'b0, 0, 0);

      // 3. latency and transparency.
      rom_fill = 8'hAB;
      probe("t3.opaque", X0, Y0, 1'b1, 1'b1, 0, 1);
      rom_fill = 8'h00;
      probe("t3.clear",  X0, Y0, 1'b1, 1'b1, 0, 1);
      rom_fill = 8'hAB;

      // 4. clamp and leading-zero blanking.
      pulse_score(1023);
      wait_cycles(12);
      probe("t4.999h", X0,      Y0, 1'b1, 1'b1, 0, 9);
      probe("t4.999t", X0 + 24, Y0, 1'b1, 1'b1, 0, 9);
      probe("t4.999o", X0 + 48, Y0, 1'b1, 1'b1, 0, 9);
      pulse_score(7);
      wait_cycles(12);
      probe("t4.7h", X0,      Y0, 1'b1, 1'b0, 0, 0);
      probe("t4.7t", X0 + 24, Y0, 1'b1, 1'b0, 0, 0);
      probe("t4.7o", X0 + 48, Y0, 1'b1, 1'b1, 0, 7);
      pulse_score(50);
      wait_cycles(12);
      probe("t4.50h", X0,      Y0, 1'b1, 1'b0, 0, 0);
      probe("t4.50t", X0 + 24, Y0, 1'b1, 1'b1, 0, 5);
      pulse_score(105);
      wait_cycles(12);
      probe("t4.105h", X0,      Y0, 1'b1, 1'b1, 0, 1);
      probe("t4.105t", X0 + 24, Y0, 1'b1, 1'b1, 0, 0);
      probe("t4.105o", X0 + 48, Y0, 1'b1, 1'b1, 0, 5);

      // 5. restart mid-conversion: 321 never reaches the display.
      hold_ones_pixel();
      pulse_score(321);
      wait_cycles(5);
      pulse_score(456);
      wait_cycles(11);
      check("t5.hold", 16'(rom_bus.o_digit_sel), 16'd5);
      @(negedge i_clk2);
      check("t5.new",  16'(rom_bus.o_digit_sel), 16'd6);
      i_active = 1'b0;
      wait_cycles(4);
      probe("t5.h", X0,      Y0, 1'b1, 1'b1, 0, 4);
      probe("t5.t", X0 + 24, Y0, 1'b1, 1'b1, 0, 5);

      // 6. reset mid-conversion clears outputs and digits, aborts conversion.
      hold_ones_pixel();
      wait_cycles(4);
      pulse_score(888);
      wait_cycles(4);
      i_rst = 1'b1;
      @(negedge i_clk2);
      check("t6.addr",  16'(rom_bus.o_numberaddr), 16'd0);
      check("t6.sel",   16'(rom_bus.o_digit_sel), 16'd0);
      check("t6.pixel", 16'(o_pixel), 16'd0);
      check("t6.hit",   16'(o_hit), 16'd0);
      check("t6.act",   16'(o_active_d), 16'd0);
      i_rst = 1'b0;
      wait_cycles(20);
      check("t6.ones",  16'(rom_bus.o_digit_sel), 16'd0);
      check("t6.ohit",  16'(o_hit), 16'd1);
      check("t6.opix",  16'(o_pixel), 16'(8'hAB ^ 8'd100));
      i_active = 1'b0;
      wait_cycles(4);
      probe("t6.h", X0,      Y0, 1'b1, 1'b0, 0, 0);
      probe("t6.t", X0 + 24, Y0, 1'b1, 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
